// File: rtl/tetris_pkg.sv
// Shared constants, FSM state encoding and helpers for the board line-clear sequencer.
// Consumed by row_cursor and line_clear_ctrl.
package tetris_pkg;

    localparam int CELL_W                = 3;
    localparam int BLOCKS_VERTICAL_DEF   = 20;
    localparam int BLOCKS_HORIZONTAL_DEF = 10;
    localparam int ADDR_W                = 5;
    localparam int LINES_W               = 5;
    localparam int TOTAL_W               = 16;

    localparam logic [CELL_W-1:0] CELL_EMPTY = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SH_RD,
        ST_SH_WR,
        ST_CLR_TOP,
        ST_FIN
    } lcc_state_e;

    function automatic logic [LINES_W-1:0] sat_inc_lines(input logic [LINES_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TOTAL_W-1:0] sat_add_total(input logic [TOTAL_W-1:0] acc,
                                                         input logic [LINES_W-1:0] inc);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, acc} + {{(TOTAL_W + 1 - LINES_W){1'b0}}, inc};
        return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/line_clear_ctrl_row_cursor.sv
// Row / column / shift-row counters for the line-clear sequencer, plus the
// boundary flags the FSM branches on.
module row_cursor
    import tetris_pkg::*;
#(
    parameter int BLOCKS_VERTICAL   = BLOCKS_VERTICAL_DEF,
    parameter int BLOCKS_HORIZONTAL = BLOCKS_HORIZONTAL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_row_load_top,
    input  logic              i_row_dec,
    input  logic              i_col_clr,
    input  logic              i_col_inc,
    input  logic              i_shf_load,
    input  logic              i_shf_dec,
    output logic [ADDR_W-1:0] o_row,
    output logic [ADDR_W-1:0] o_col,
    output logic [ADDR_W-1:0] o_shf,
    output logic              o_col_last,
    output logic              o_row_top,
    output logic              o_shf_one
);

    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(BLOCKS_VERTICAL - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(BLOCKS_HORIZONTAL - 1);

    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_shf;

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples the pre-edge value of its neighbours (r_shf loads the old r_row).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
            r_shf <= '0;
        end else begin
            if (i_row_load_top) begin
                r_row <= ROW_LAST;
            end else if (i_row_dec) begin
                r_row <= r_row - 1'b1;
            end

            if (i_col_clr) begin
                r_col <= '0;
            end else if (i_col_inc) begin
                r_col <= r_col + 1'b1;
            end

            if (i_shf_load) begin
                r_shf <= r_row;
            end else if (i_shf_dec) begin
                r_shf <= r_shf - 1'b1;
            end
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_shf      = r_shf;
    assign o_col_last = (r_col == COL_LAST);
    assign o_row_top  = (r_row == '0);
    assign o_shf_one  = (r_shf == ADDR_W'(1));

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board bottom-up, collapses full rows and
// reports the count. Optional LINE_CLEAR_STATS_EN adds total_lines / tetris_flag.
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int BLOCKS_VERTICAL   = BLOCKS_VERTICAL_DEF,
    parameter int BLOCKS_HORIZONTAL = BLOCKS_HORIZONTAL_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [LINES_W-1:0]  lines_cleared,
    output logic [ADDR_W-1:0]   mem_vaddr,
    output logic [ADDR_W-1:0]   mem_haddr,
    input  logic [CELL_W-1:0]   mem_rdata,
    output logic                mem_we,
    output logic [CELL_W-1:0]   mem_wdata
`ifdef LINE_CLEAR_STATS_EN
   ,output logic [TOTAL_W-1:0]  total_lines,
    output logic                tetris_flag
`endif
);

    lcc_state_e         r_state;
    logic [CELL_W-1:0]  r_hold;
    logic [LINES_W-1:0] r_lines;
    logic               r_busy;
    logic               r_done;
    logic [LINES_W-1:0] r_lines_cleared;
`ifdef LINE_CLEAR_STATS_EN
    logic [TOTAL_W-1:0] r_total;
    logic               r_tetris;
`endif

    logic              w_row_load_top;
    logic              w_row_dec;
    logic              w_col_clr;
    logic              w_col_inc;
    logic              w_shf_load;
    logic              w_shf_dec;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_shf;
    logic              w_col_last;
    logic              w_row_top;
    logic              w_shf_one;
    logic              w_cell_full;

    assign w_cell_full = (mem_rdata != CELL_EMPTY);

    row_cursor #(
        .BLOCKS_VERTICAL   (BLOCKS_VERTICAL),
        .BLOCKS_HORIZONTAL (BLOCKS_HORIZONTAL)
    ) u_row_cursor (
        .clk            (clk),
        .reset          (reset),
        .i_row_load_top (w_row_load_top),
        .i_row_dec      (w_row_dec),
        .i_col_clr      (w_col_clr),
        .i_col_inc      (w_col_inc),
        .i_shf_load     (w_shf_load),
        .i_shf_dec      (w_shf_dec),
        .o_row          (w_row),
        .o_col          (w_col),
        .o_shf          (w_shf),
        .o_col_last     (w_col_last),
        .o_row_top      (w_row_top),
        .o_shf_one      (w_shf_one)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        w_row_load_top = 1'b0;
        w_row_dec      = 1'b0;
        w_col_clr      = 1'b0;
        w_col_inc      = 1'b0;
        w_shf_load     = 1'b0;
        w_shf_dec      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_row_load_top = 1'b1;
                    w_col_clr      = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!w_cell_full) begin
                    if (!w_row_top) begin
                        w_row_dec = 1'b1;
                        w_col_clr = 1'b1;
                    end
                end else if (!w_col_last) begin
                    w_col_inc = 1'b1;
                end else begin
                    w_shf_load = 1'b1;
                    w_col_clr  = 1'b1;
                end
            end
            ST_SH_WR: begin
                if (!w_col_last) begin
                    w_col_inc = 1'b1;
                end else begin
                    w_col_clr = 1'b1;
                    w_shf_dec = !w_shf_one;
                end
            end
            ST_CLR_TOP: begin
                if (!w_col_last) begin
                    w_col_inc = 1'b1;
                end else begin
                    w_col_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_hold          <= CELL_EMPTY;
            r_lines         <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_lines_cleared <= '0;
`ifdef LINE_CLEAR_STATS_EN
            r_total         <= '0;
            r_tetris        <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LINE_CLEAR_STATS_EN
            r_tetris <= 1'b0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_lines <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_cell_full) begin
                        if (w_row_top) begin
                            r_state         <= ST_FIN;
                            r_done          <= 1'b1;
                            r_lines_cleared <= r_lines;
`ifdef LINE_CLEAR_STATS_EN
                            r_total  <= sat_add_total(r_total, r_lines);
                            r_tetris <= (r_lines == LINES_W'(4));
`endif
                        end
                    end else if (w_col_last) begin
                        r_lines <= sat_inc_lines(r_lines);
                        r_state <= w_row_top ? ST_CLR_TOP : ST_SH_RD;
                    end
                end
                ST_SH_RD: begin
                    r_hold  <= mem_rdata;
                    r_state <= ST_SH_WR;
                end
                ST_SH_WR: begin
                    if (!w_col_last) begin
                        r_state <= ST_SH_RD;
                    end else begin
                        r_state <= w_shf_one ? ST_CLR_TOP : ST_SH_RD;
                    end
                end
                ST_CLR_TOP: begin
                    if (w_col_last) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory port is a pure decode of registered state: read data returns in
    // the same cycle, so the address must track the current cursor.
    always_comb begin
        mem_vaddr = '0;
        mem_haddr = '0;
        mem_we    = 1'b0;
        mem_wdata = CELL_EMPTY;
        unique case (r_state)
            ST_SCAN: begin
                mem_vaddr = w_row;
                mem_haddr = w_col;
            end
            ST_SH_RD: begin
                mem_vaddr = w_shf - 1'b1;
                mem_haddr = w_col;
            end
            ST_SH_WR: begin
                mem_vaddr = w_shf;
                mem_haddr = w_col;
                mem_we    = 1'b1;
                mem_wdata = r_hold;
            end
            ST_CLR_TOP: begin
                mem_haddr = w_col;
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign lines_cleared = r_lines_cleared;
`ifdef LINE_CLEAR_STATS_EN
    assign total_lines   = r_total;
    assign tetris_flag   = r_tetris;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: random and directed boards are compacted
// by a row-list reference model; a monitor compares results on every done pulse.
module tb_line_clear_ctrl;
    import tetris_pkg::*;

    localparam int V = 20;
    localparam int H = 10;

    typedef logic [CELL_W-1:0] board_t [V][H];
    typedef struct {
        board_t brd;
        int     lines;
        int     writes;
        int     lat;
        int     total;
        int     tetris;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic [LINES_W-1:0] lines_cleared;
    logic [ADDR_W-1:0]  mem_vaddr;
    logic [ADDR_W-1:0]  mem_haddr;
    logic [CELL_W-1:0]  mem_rdata;
    logic               mem_we;
    logic [CELL_W-1:0]  mem_wdata;
`ifdef LINE_CLEAR_STATS_EN
    logic [TOTAL_W-1:0] total_lines;
    logic               tetris_flag;
`endif

    line_clear_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem_vaddr     (mem_vaddr),
        .mem_haddr     (mem_haddr),
        .mem_rdata     (mem_rdata),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata)
`ifdef LINE_CLEAR_STATS_EN
       ,.total_lines   (total_lines),
        .tetris_flag   (tetris_flag)
`endif
    );

    always #5 clk = ~clk;

    board_t board;
    board_t stage;
    logic   load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) board <= stage;
        else if (mem_we && mem_vaddr < 5'(V) && mem_haddr < 5'(H))
            board[mem_vaddr][mem_haddr] <= mem_wdata;
    end

    assign mem_rdata = (mem_vaddr < 5'(V) && mem_haddr < 5'(H)) ? board[mem_vaddr][mem_haddr] : '0;

    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;
    int   cnt_busy = 0;
    int   cnt_we = 0;
    int   exp_total = 0;
    exp_t q[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int board_diff(input board_t e);
        int n = 0;
        for (int i = 0; i < V; i++)
            for (int j = 0; j < H; j++)
                if (board[i][j] !== e[i][j]) n++;
        return n;
    endfunction

    // Reference: keep non-full rows in bottom-up order and stack them at the
    // bottom. A full row at original index i sits at i + (full rows below it)
    // when it is cleared; it costs one write per cell of every row above plus the top row.
    function automatic void model(input board_t b, output board_t f,
                                  output int lines, output int writes);
        int pos;
        bit full;
        pos = V - 1;
        lines = 0;
        writes = 0;
        for (int i = 0; i < V; i++)
            for (int j = 0; j < H; j++)
                f[i][j] = '0;
        for (int i = V - 1; i >= 0; i--) begin
            full = 1'b1;
            for (int j = 0; j < H; j++)
                if (b[i][j] == '0) full = 1'b0;
            if (full) begin
                writes += H * (i + lines + 1);
                lines++;
            end else begin
                f[pos] = b[i];
                pos--;
            end
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt_busy = 0;
                cnt_we   = 0;
            end else begin
                if (busy)   cnt_busy++;
                if (mem_we) cnt_we++;
                if (done) begin
                    done_seen++;
                    if (q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("lines_cleared", int'(lines_cleared), e.lines);
                        check("board_cells_wrong", board_diff(e.brd), 0);
                        check("write_count", cnt_we, e.writes);
                        if (e.lat >= 0) check("latency", cnt_busy, e.lat);
`ifdef LINE_CLEAR_STATS_EN
                        check("total_lines", int'(total_lines), e.total);
                        check("tetris_flag", int'(tetris_flag), e.tetris);
`endif
                    end
                    cnt_busy = 0;
                    cnt_we   = 0;
                end
            end
        end
    end

    task automatic run_pass(input board_t b, input int lat, input bit dbl, input bit fin_start);
        exp_t e;
        int prev;
        int n;
        @(negedge clk);
        stage   = b;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        model(b, e.brd, e.lines, e.writes);
        e.lat     = lat;
        exp_total = (exp_total + e.lines > 65535) ? 65535 : exp_total + e.lines;
        e.total   = exp_total;
        e.tetris  = (e.lines == 4) ? 1 : 0;
        q.push_back(e);
        prev  = done_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (dbl) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (fin_start) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_after_fin_start", int'(busy), 0);
        end
        n = 0;
        while (done_seen == prev && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == prev) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
        repeat (3) @(negedge clk);
        check("idle_after_pass", int'(busy), 0);
    endtask

    function automatic board_t empty_board();
        board_t b;
        for (int i = 0; i < V; i++)
            for (int j = 0; j < H; j++)
                b[i][j] = '0;
        return b;
    endfunction

    function automatic board_t random_board();
        board_t b;
        for (int i = 0; i < V; i++) begin
            bit full = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < H; j++) begin
                if (full || $urandom_range(0, 3) != 0) b[i][j] = CELL_W'($urandom_range(1, 7));
                else b[i][j] = '0;
            end
        end
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        board_t b;
        int n;

        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_lines_cleared", int'(lines_cleared), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_mem_vaddr", int'(mem_vaddr), 0);
        check("rst_mem_haddr", int'(mem_haddr), 0);
`ifdef LINE_CLEAR_STATS_EN
        check("rst_total_lines", int'(total_lines), 0);
        check("rst_tetris_flag", int'(tetris_flag), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Empty board: 20 scan cycles + FIN, no writes.
        run_pass(empty_board(), 21, 1'b0, 1'b0);
        // Empty board again, with start landing on the FIN cycle.
        run_pass(empty_board(), 21, 1'b0, 1'b1);

        // Row 19 full, one stray cell above it.
        b = empty_board();
        for (int j = 0; j < H; j++) b[19][j] = 3'd3;
        b[18][4] = 3'd5;
        run_pass(b, -1, 1'b0, 1'b0);

        // Four full rows under an alternating row.
        b = empty_board();
        for (int i = 16; i < 20; i++)
            for (int j = 0; j < H; j++) b[i][j] = CELL_W'((i + j) % 7 + 1);
        for (int j = 0; j < H; j++) b[15][j] = (j % 2 == 0) ? 3'd1 : 3'd0;
        run_pass(b, -1, 1'b0, 1'b0);

        // Only the top row full.
        b = empty_board();
        for (int j = 0; j < H; j++) b[0][j] = 3'd6;
        run_pass(b, -1, 1'b0, 1'b0);

        // Second start while busy must not queue another pass.
        b = random_board();
        for (int j = 0; j < H; j++) b[19][j] = 3'd2;
        run_pass(b, -1, 1'b1, 1'b0);

        // Reset during a shift write of a two-line pass.
        b = empty_board();
        for (int i = 18; i < 20; i++)
            for (int j = 0; j < H; j++) b[i][j] = 3'd4;
        b[12][3] = 3'd7;
        b[17][0] = 3'd1;
        @(negedge clk);
        stage   = b;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_we && mem_vaddr != '0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_shift_write", int'(mem_we && mem_vaddr != '0), 1);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_mem_we", int'(mem_we), 0);
        @(negedge clk);
        reset     = 1'b0;
        exp_total = 0;
        run_pass(b, -1, 1'b0, 1'b0);

        // Randomised boards.
        for (int k = 0; k < 15; k++)
            run_pass(random_board(), -1, (k % 5 == 4), 1'b0);

        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
- Sequencer that owns the game-board memory port after a piece locks.
- Scans rows bottom-up for completely filled rows and shifts every row above each full row down by one. Clears the top row to empty and reports how many lines were removed.
- Sits between the game FSM, which pulses start, and the board memory.
- Drives one shared address, a combinational read-data return and a write strobe.

Parameters:
- BLOCKS_VERTICAL, 20, number of rows; row 0 is the top row.
- BLOCKS_HORIZONTAL, 10, number of columns.
- CELL_W, 3, width of a cell colour code; 0 means empty.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to run a clear pass; ignored unless in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the pass finishes.
- lines_cleared  output  5  full rows removed in the last pass.
- mem_vaddr  output  5  row address to board memory.
- mem_haddr  output  5  column address to board memory.
- mem_rdata  input  CELL_W  cell value at (mem_vaddr, mem_haddr), combinational, same cycle.
- mem_we  output  1  write strobe, sampled by memory on clk rising edge.
- mem_wdata  output  CELL_W  write data.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values:
  - busy=0, done=0, lines_cleared=0.
  - mem_we=0, mem_wdata=0, mem_vaddr=0, mem_haddr=0.
  - FSM is in IDLE.
- Reset mid-pass aborts immediately. Board contents may be partially shifted; the game FSM must re-init the board.
- Registers: row r, column c, shift row s, hold register h (CELL_W bits), lines counter.
- States: IDLE, SCAN, SH_RD, SH_WR, CLR_TOP, FIN.
- IDLE:
  - On start, go to SCAN with r=BLOCKS_VERTICAL-1, c=0, lines=0.
  - busy rises the next cycle.
- SCAN (one cell per cycle, address=(r,c)):
  - rdata==0: row not full. If r==0 go to FIN; else r=r-1, c=0.
  - rdata!=0 and c<BLOCKS_HORIZONTAL-1: c=c+1.
  - rdata!=0 and c==BLOCKS_HORIZONTAL-1: row full. Increment lines (saturating at 31) and set s=r, c=0. Go to SH_RD if s>0, else CLR_TOP.
- SH_RD: address=(s-1,c); latch h=rdata; go to SH_WR.
- SH_WR: address=(s,c); mem_we=1, wdata=h.
  - Then if c<BLOCKS_HORIZONTAL-1: c=c+1, go to SH_RD.
  - Else c=0. If s>1: s=s-1, go to SH_RD. Else go to CLR_TOP.
- CLR_TOP:
  - Address=(0,c); mem_we=1, wdata=0; c increments each cycle.
  - After column BLOCKS_HORIZONTAL-1, go to SCAN with the same r and c=0. The same row is rescanned because new contents moved into it.
- FIN: done=1 for one cycle; lines_cleared=lines; busy=0 next cycle; go to IDLE.
- lines_cleared holds its value until the next FIN. It is not cleared on start.
- mem_we is high only in SH_WR and CLR_TOP.
- Timing:
  - Cycle costs: a row whose first empty cell is at column k costs k+1 SCAN cycles; a full row costs BLOCKS_HORIZONTAL SCAN cycles.
  - Per-clear cost: 2·BLOCKS_HORIZONTAL·r shift cycles plus BLOCKS_HORIZONTAL CLR_TOP cycles.
  - start to done: empty board → BLOCKS_VERTICAL SCAN cycles + 1 FIN cycle.
- Boundaries:
  - Full row at r=0: skip shifting, go straight to CLR_TOP.
  - start while busy: ignored, no queuing.
  - start coincident with the FIN cycle: ignored.
- Addresses are zero-extended to 5 bits. BLOCKS_VERTICAL and BLOCKS_HORIZONTAL must each be ≤32.

Optional Feature:
- Macro: LINE_CLEAR_STATS_EN.
- With the macro defined:
  - Adds output total_lines [15:0], reset to 0.
  - Adds output tetris_flag [0:0], reset to 0.
  - total_lines accumulates lines on each FIN and saturates at 16'hFFFF.
  - tetris_flag is set for one cycle together with done when lines==4.
- Without the macro: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package (tetris_pkg):
  - CELL_W and the CELL_EMPTY=0 constant.
  - Board dimension defaults.
  - FSM state enum for line_clear_ctrl.
- Sub-module: row_cursor. It holds the r/c/s counters with increment, decrement and wrap flags (col_last, row_top), used by the FSM.

Test Plan:
- Empty board, pulse start → mem_we never asserted; done exactly 21 cycles after start accepted; lines_cleared=0.
- Row 19 all colour 3, row 18 col 4 = colour 5, rest empty → row 19 gets col4=5 and 0 elsewhere; row 0 all 0; lines_cleared=1.
- Rows 16–19 full, row 15 = alternating 1/0 → rows 15–18 are 0 and row 19 holds the alternating pattern; lines_cleared=4; with LINE_CLEAR_STATS_EN, tetris_flag pulses and total_lines=4.
- Only row 0 full → no SH_RD cycles; exactly 10 CLR_TOP writes to row 0; lines_cleared=1.
- Assert reset during SH_WR of a 2-line pass → busy, done and mem_we are 0 in the same cycle; FSM is in IDLE; a following start is accepted.
- start pulsed again while busy → ignored; exactly one done pulse per accepted start.
